hp_sr_round: RTL and testbench
==============================

// Module: hp_sr_round
// PURPOSE
//  Rounding back-end for the hp_mul datapath. Takes the truncated result, extended mantissa (round_mant) and class flags.
//  Applies stochastic rounding (SR) using an internal LFSR and emits the final packed FP word with corrected class flags.
//  Single registered stage with valid/ready handshake; sits between the multiplier and the FPU writeback.
// PARAMETERS
//  NUM_BITS        16       packed FP width (16 or 32)
//  EXP_WIDTH       5        exponent field width
//  MANT_WIDTH      10       stored mantissa width
//  NUM_ROUND_BITS  8        extra fraction bits below mantissa LSB (1..16)
//  LFSR_SEED       16'hACE1 LFSR reset value; must be non-zero
// PORTS
//  clk            in   1                        clock
//  rst_n          in   1                        async active-low reset
//  in_valid       in   1                        upstream result valid
//  in_ready       out  1                        stage can accept
//  in_result      in   NUM_BITS                 truncated packed result
//  in_round_mant  in   MANT_WIDTH+NUM_ROUND_BITS  {mantissa, round fraction}
//  in_zero/in_inf/in_subN/in_Norm/in_QNan/in_SNan  in 1 each   one-hot class of in_result
//  out_valid      out  1                        rounded result valid
//  out_ready      in   1                        downstream accepts
//  out_result     out  NUM_BITS                 rounded packed result
//  out_zero/out_inf/out_subN/out_Norm/out_QNan/out_SNan  out 1 each  class after rounding
//  rnd_mode       in   1                        only with HP_SR_RNE_EN: 0=SR, 1=RNE
// BEHAVIOUR
//  Reset: out_valid=0, out_result=0, all out flags=0, lfsr=LFSR_SEED. Reset is honoured mid-operation; a held result is dropped.
//  in_ready = !out_valid | out_ready. Accept = in_valid & in_ready. The output register loads on accept.
//  On out_valid & out_ready & !in_valid, out_valid clears. Latency 1 cycle; throughput 1/cycle.
//  out_* hold stable while out_valid & !out_ready.
//  LFSR: 16-bit Galois, poly 0xB400, shifts once per accept (every class, incl. pass-through).
//  The random value r = lfsr[NUM_ROUND_BITS-1:0] sampled before the shift.
//  Round only when in_Norm | in_subN, with f = in_round_mant[NUM_ROUND_BITS-1:0]:
//   - up = carry-out of (f + r) over NUM_ROUND_BITS bits, i.e. P(up) = f/2^NUM_ROUND_BITS.
//   - Magnitude {exp,mant} = in_result[NUM_BITS-2:0] + up; the sign is unchanged.
//   - Mantissa carry propagates into the exponent naturally.
//   - Class after rounding: exp==all-ones -> out_inf (mant is 0 by construction).
//     exp!=0 -> out_Norm, incl. subN 0x03FF -> 0x0400. Otherwise -> out_subN.
//  zero/inf/QNan/SNan inputs pass through unchanged: out_result=in_result, flags copied, round bits ignored.
//  Multiple or zero in-flag bits asserted: treated as pass-through. Not expected; assertion in bench.
// CONFIGURATION
//  HP_SR_RNE_EN defined: adds rnd_mode port.
//   - rnd_mode=1 selects round-to-nearest-even: up = f[MSB] & (f[MSB-1:0]!=0 | mant LSB).
//   - The LFSR still advances.
//  Undefined: SR only, no rnd_mode port.
// STRUCTURE
//  hp_fp_pkg: fp_class_t struct {zero,inf,subN,Norm,QNan,SNan}, bias/exp constants per width, LFSR_POLY=16'hB400.
//  Sub-module hp_lfsr16 (clk, rst_n, seed, step, state); rounding add/reclassify is combinational in hp_sr_round.
// TESTING (FP16, NUM_ROUND_BITS=8, out_ready=1 unless stated)
//  1. Norm 0x3C00, f=0x00, 256 accepts -> always 0x3C00, out_Norm; never rounds up.
//  2. Norm 0x3BFF, mant=0x3FF, f=0xFF, r=0x01 -> 0x3C00, out_Norm.
//  3. Norm 0x7BFF, f=0x80, r>=0x80 -> 0x7C00, out_inf=1, out_Norm=0; with r<0x80 -> 0x7BFF.
//  4. subN 0x03FF, f=0xFF, r!=0 -> 0x0400, out_Norm=1; subN 0x0001, f=0x00 -> 0x0001, out_subN.
//  5. SNan 0x7D00, f=0xFF -> 0x7D00 out_SNan unchanged; LFSR state advanced by one.
//  6. Hold out_ready=0 for 3 cycles -> in_ready=0, out stable.
//     Then assert rst_n=0 mid-hold -> out_valid=0, lfsr=LFSR_SEED.
//     Separately: f=0x40 over 4096 samples -> round-up rate 25%+-3%.

Source files
------------

// File: rtl/hp_fp_pkg.sv
// Shared types and constants for the hp_mul floating-point back-end.
package hp_fp_pkg;

    localparam int unsigned LFSR_W      = 16;
    localparam logic [15:0] LFSR_POLY   = 16'hB400;

    localparam int unsigned FP16_EXP_W  = 5;
    localparam int unsigned FP16_MANT_W = 10;
    localparam int unsigned FP16_BIAS   = 15;
    localparam int unsigned FP32_EXP_W  = 8;
    localparam int unsigned FP32_MANT_W = 23;
    localparam int unsigned FP32_BIAS   = 127;

    // One-hot class of a packed FP value
    typedef struct packed {
        logic zero;
        logic inf;
        logic subN;
        logic Norm;
        logic QNan;
        logic SNan;
    } fp_class_t;

    // One step of the right-shifting Galois LFSR
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] shifted;
        shifted = s >> 1;
        return s[0] ? (shifted ^ LFSR_POLY) : shifted;
    endfunction

endpackage

// File: rtl/hp_lfsr16.sv
// 16-bit Galois LFSR that advances only when stepped; loads seed on reset.
module hp_lfsr16
    import hp_fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    // State register: reload seed on reset, advance one step per request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/hp_sr_round.sv
// Stochastic-rounding back-end for hp_mul: one registered valid/ready stage.
// Optional build macro HP_SR_RNE_EN adds rnd_mode (1 = round-to-nearest-even).
module hp_sr_round
    import hp_fp_pkg::*;
#(
    parameter int unsigned NUM_BITS       = 16,
    parameter int unsigned EXP_WIDTH      = 5,
    parameter int unsigned MANT_WIDTH     = 10,
    parameter int unsigned NUM_ROUND_BITS = 8,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                               clk,
    input  logic                               rst_n,
`ifdef HP_SR_RNE_EN
    input  logic                               rnd_mode,
`endif
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_BITS-1:0]                in_result,
    input  logic [MANT_WIDTH+NUM_ROUND_BITS-1:0] in_round_mant,
    input  logic                               in_zero,
    input  logic                               in_inf,
    input  logic                               in_subN,
    input  logic                               in_Norm,
    input  logic                               in_QNan,
    input  logic                               in_SNan,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_BITS-1:0]                out_result,
    output logic                               out_zero,
    output logic                               out_inf,
    output logic                               out_subN,
    output logic                               out_Norm,
    output logic                               out_QNan,
    output logic                               out_SNan
);

    localparam int unsigned MAG_W = NUM_BITS - 1;

    fp_class_t                  in_class;
    fp_class_t                  out_class;
    fp_class_t                  rnd_class;
    fp_class_t                  next_class;
    logic [LFSR_W-1:0]          lfsr_state;
    logic                       accept;
    logic [NUM_ROUND_BITS-1:0]  frac;
    logic [NUM_ROUND_BITS-1:0]  rnd;
    logic [NUM_ROUND_BITS:0]    frac_sum;
    logic                       up;
    logic                       round_en;
    logic [MAG_W-1:0]           mag;
    logic [EXP_WIDTH-1:0]       exp_f;
    logic [NUM_BITS-1:0]        next_result;
    logic                       unused_bits;

`ifdef HP_SR_RNE_EN
    localparam logic [NUM_ROUND_BITS-1:0] HALF = NUM_ROUND_BITS'(1) << (NUM_ROUND_BITS - 1);
`endif

    assign in_class  = {in_zero, in_inf, in_subN, in_Norm, in_QNan, in_SNan};
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // Mantissa bits above the round fraction are already in in_result; LFSR top bits are not sampled
    assign unused_bits = ^{in_round_mant, lfsr_state};

    // Random source; advances on every accepted transfer regardless of class
    hp_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .step  (accept),
        .state (lfsr_state)
    );

    // Round-up decision, magnitude increment and reclassification
    always_comb begin
        frac        = in_round_mant[NUM_ROUND_BITS-1:0];
        rnd         = lfsr_state[NUM_ROUND_BITS-1:0];
        frac_sum    = {1'b0, frac} + {1'b0, rnd};
        up          = frac_sum[NUM_ROUND_BITS];
`ifdef HP_SR_RNE_EN
        if (rnd_mode) begin
            up = frac[NUM_ROUND_BITS-1] &&
                 ((|(frac & ~HALF)) || in_round_mant[NUM_ROUND_BITS]);
        end
`endif
        round_en    = (in_Norm || in_subN) && $onehot(in_class);
        mag         = in_result[MAG_W-1:0] + MAG_W'(up);
        exp_f       = mag[MAG_W-1 -: EXP_WIDTH];

        rnd_class   = '0;
        if (&exp_f) begin
            rnd_class.inf = 1'b1;
        end else if (|exp_f) begin
            rnd_class.Norm = 1'b1;
        end else begin
            rnd_class.subN = 1'b1;
        end

        next_result = in_result;
        next_class  = in_class;
        if (round_en) begin
            next_result = {in_result[NUM_BITS-1], mag};
            next_class  = rnd_class;
        end
    end

    // Output stage: load on accept, drop valid once drained, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_class  <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= next_result;
            out_class  <= next_class;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    assign out_zero = out_class.zero;
    assign out_inf  = out_class.inf;
    assign out_subN = out_class.subN;
    assign out_Norm = out_class.Norm;
    assign out_QNan = out_class.QNan;
    assign out_SNan = out_class.SNan;

endmodule

// File: tb/tb_hp_sr_round.sv
// Bench for hp_sr_round (FP16, 8 round bits): arithmetic reference model plus directed literals.
module tb_hp_sr_round;

    localparam logic [5:0] F_ZERO = 6'b100000;
    localparam logic [5:0] F_INF  = 6'b010000;
    localparam logic [5:0] F_SUBN = 6'b001000;
    localparam logic [5:0] F_NORM = 6'b000100;
    localparam logic [5:0] F_QNAN = 6'b000010;
    localparam logic [5:0] F_SNAN = 6'b000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_res = '0;
    logic [17:0] in_rm = '0;
    logic [5:0]  in_fl = F_ZERO;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic        out_zero, out_inf, out_subN, out_Norm, out_QNan, out_SNan;
    logic [5:0]  out_fl;

    int tests = 0;
    int fails = 0;
    int phase = 0;
    int n1 = 0, bad1 = 0, n2 = 0, ups = 0;
    bit rnd_ready = 1'b0;

    always #5 clk = ~clk;

    assign out_fl = {out_zero, out_inf, out_subN, out_Norm, out_QNan, out_SNan};

    hp_sr_round dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef HP_SR_RNE_EN
        .rnd_mode      (1'b0),
`endif
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_res),
        .in_round_mant (in_rm),
        .in_zero       (in_fl[5]),
        .in_inf        (in_fl[4]),
        .in_subN       (in_fl[3]),
        .in_Norm       (in_fl[2]),
        .in_QNan       (in_fl[1]),
        .in_SNan       (in_fl[0]),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_inf       (out_inf),
        .out_subN      (out_subN),
        .out_Norm      (out_Norm),
        .out_QNan      (out_QNan),
        .out_SNan      (out_SNan)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one-deep output register, arithmetic rounding from the rules
    logic        m_valid;
    logic [15:0] m_res;
    logic [5:0]  m_fl;
    logic [15:0] m_lfsr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_res   = '0;
            m_fl    = '0;
            m_lfsr  = 16'hACE1;
        end else if (in_valid && (!m_valid || out_ready)) begin
            int r, f, mag, e;
            r = int'(m_lfsr) % 256;
            f = int'(in_rm) % 256;
            if ($onehot(in_fl) && (in_fl == F_NORM || in_fl == F_SUBN)) begin
                mag   = (int'(in_res) % 32768) + ((f + r >= 256) ? 1 : 0);
                e     = mag / 1024;
                m_fl  = (e == 31) ? F_INF : (e != 0) ? F_NORM : F_SUBN;
                m_res = {in_res[15], 15'(mag)};
            end else begin
                m_res = in_res;
                m_fl  = in_fl;
            end
            m_lfsr  = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 16'hB400) : (m_lfsr / 2);
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    end

    // Per-cycle comparison against the model, plus phase statistics
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            if (m_valid) begin
                chk("out_result", 32'(out_result), 32'(m_res));
                chk("out_flags", 32'(out_fl), 32'(m_fl));
            end
            if (out_valid && out_ready) begin
                if (phase == 1) begin
                    n1++;
                    if (out_result != 16'h3C00) bad1++;
                end
                if (phase == 2) begin
                    n2++;
                    if (out_result == 16'h3C01) ups++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && in_valid)
            assert ($onehot(in_fl)) else $error("class flags not one-hot: %b", in_fl);
    end

    // Random backpressure when enabled
    always @(posedge clk) begin
        if (rnd_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present one transfer, starting just after a rising edge; returns just after the accepting edge
    task automatic push(input logic [15:0] res, input logic [5:0] fl, input logic [17:0] rm);
        bit acc;
        int n;
        in_res   = res;
        in_fl    = fl;
        in_rm    = rm;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("push_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic lit(input string name, input logic [15:0] res, input logic [5:0] fl);
        chk({name, "_res"}, 32'(out_result), 32'(res));
        chk({name, "_cls"}, 32'(out_fl), 32'(fl));
    endtask

    initial begin
        logic [15:0] res;
        logic [5:0]  fl;
        int          k;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_flags", 32'(out_fl), 32'd0);
        chk("rst_lfsr", 32'(dut.u_lfsr.state), 32'hACE1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed literals; r sequence from seed ACE1 is E1,70,38,9C,4E,27
        push(16'h7BFF, F_NORM, {10'h3FF, 8'h80});
        lit("ovf_to_inf", 16'h7C00, F_INF);
        push(16'h7BFF, F_NORM, {10'h3FF, 8'h80});
        lit("max_norm_hold", 16'h7BFF, F_NORM);
        push(16'h03FF, F_SUBN, {10'h3FF, 8'hFF});
        lit("subn_to_norm", 16'h0400, F_NORM);
        push(16'h3BFF, F_NORM, {10'h3FF, 8'hFF});
        lit("mant_carry", 16'h3C00, F_NORM);
        push(16'h0001, F_SUBN, {10'h001, 8'h00});
        lit("subn_keep", 16'h0001, F_SUBN);
        push(16'h7D00, F_SNAN, {10'h100, 8'hFF});
        lit("snan_pass", 16'h7D00, F_SNAN);
        chk("lfsr_after6", 32'(dut.u_lfsr.state), 32'hB313);

        // Zero fraction never rounds up
        @(posedge clk);
        #1;
        phase = 1;
        repeat (256) push(16'h3C00, F_NORM, {10'h000, 8'h00});
        repeat (3) @(posedge clk);
        #1;
        phase = 0;
        chk("f0_count", 32'(n1), 32'd256);
        chk("f0_roundups", 32'(bad1), 32'd0);

        // Stall holds output, then reset drops it
        out_ready = 1'b0;
        push(16'h4000, F_NORM, {10'h000, 8'h00});
        lit("hold_load", 16'h4000, F_NORM);
        in_res   = 16'h4400;
        in_fl    = F_NORM;
        in_rm    = {10'h000, 8'hFF};
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", 32'(out_result), 32'h4000);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", 32'(out_result), 32'd0);
        chk("midrst_lfsr", 32'(dut.u_lfsr.state), 32'hACE1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-up rate with f = 0x40 should be about one quarter
        phase = 2;
        repeat (4096) push(16'h3C00, F_NORM, {10'h000, 8'h40});
        repeat (3) @(posedge clk);
        #1;
        phase = 0;
        chk("sr_count", 32'(n2), 32'd4096);
        tests++;
        if (ups < 901 || ups > 1147) begin
            fails++;
            $display("FAIL sr_rate: got %0d round-ups of 4096, expected 901..1147", ups);
        end

        // Mixed classes under random backpressure, checked by the model
        rnd_ready = 1'b1;
        repeat (300) begin
            k = $urandom_range(0, 5);
            case (k)
                0: begin res = {1'($urandom_range(0, 1)), 15'h0000}; fl = F_ZERO; end
                1: begin res = 16'h7C00; fl = F_INF; end
                2: begin res = {1'($urandom_range(0, 1)), 5'd0, 10'($urandom)}; fl = F_SUBN; end
                3: begin res = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom)}; fl = F_NORM; end
                4: begin res = {6'b011111, 10'($urandom) | 10'h200}; fl = F_QNAN; end
                default: begin res = {6'b011111, 1'b0, 9'($urandom) | 9'h001}; fl = F_SNAN; end
            endcase
            push(res, fl, 18'($urandom));
        end
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
